// File: rtl/fa_pkg.sv
// fa_pkg: shared width default and sum-plus-carry result type for the ripple adder
`timescale 1ns/1ps
package fa_pkg;
    localparam int WIDTH_DEFAULT = 1;
    typedef logic [WIDTH_DEFAULT:0] fa_result_t;
endpackage

// File: rtl/half_adder.sv
// half_adder: single-bit sum and carry of two inputs
`timescale 1ns/1ps
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);
    assign sum   = x ^ y;
    assign carry = x & y;
endmodule

// File: rtl/fa_using_2ha.sv
// fa_using_2ha: ripple-carry adder built from two half adders per bit, with enabled output register
`timescale 1ns/1ps
module fa_using_2ha
    import fa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             en,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic [WIDTH-1:0] s_q,
    output logic             co_q
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] p, g1, g2;
    assign c[0] = ci;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        half_adder u_ha1 (.x(a[i]), .y(b[i]), .sum(p[i]), .carry(g1[i]));
        half_adder u_ha2 (.x(p[i]), .y(c[i]), .sum(s[i]), .carry(g2[i]));
        assign c[i+1] = g1[i] | g2[i];
    end
    assign co = c[WIDTH];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {co_q, s_q} <= '0;
        else if (en) {co_q, s_q} <= {co, s};
endmodule

// File: tb/tb_fa_using_2ha.sv
// tb_fa_using_2ha: randomized check of 1/8/32-bit adders against an arithmetic reference
`timescale 1ns/1ps
module tb_fa_using_2ha;
    logic clk = 0, rst_n = 0, ci = 0, en = 0;
    logic        a1 = 0, b1 = 0, s1, co1, sq1, coq1;
    logic [7:0]  a8 = 0, b8 = 0, s8, sq8;
    logic        co8, coq8;
    logic [31:0] a32 = 0, b32 = 0, s32, sq32;
    logic        co32, coq32;
    logic [64:0] e1, e8, e32, q1, q8, q32;
    int n_checks = 0, n_fail = 0;
    logic [7:0] s_tab, co_tab;

    fa_using_2ha #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci), .en(en),
        .s(s1), .co(co1), .s_q(sq1), .co_q(coq1));
    fa_using_2ha #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci), .en(en),
        .s(s8), .co(co8), .s_q(sq8), .co_q(coq8));
    fa_using_2ha #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .ci(ci), .en(en),
        .s(s32), .co(co32), .s_q(sq32), .co_q(coq32));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model();
        e1  = 65'(a1) + 65'(b1) + 65'(ci);
        e8  = 65'(a8) + 65'(b8) + 65'(ci);
        e32 = 65'(a32) + 65'(b32) + 65'(ci);
    endtask

    task automatic check_comb();
        model();
        check("sum1", {co1, s1}, e1);
        check("sum8", {co8, s8}, e8);
        check("sum32", {co32, s32}, e32);
    endtask

    task automatic check_reg();
        check("reg1", {coq1, sq1}, q1);
        check("reg8", {coq8, sq8}, q8);
        check("reg32", {coq32, sq32}, q32);
    endtask

    initial begin
        q1 = 0; q8 = 0; q32 = 0;
        #1;
        check_reg();
        // 1-bit truth table, stepping ci/b/a at 1/2/4 ns
        s_tab  = 8'b1001_0110;
        co_tab = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, ci} = 3'(i);
            #1;
            check("tt_s", 65'(s1), 65'(s_tab[i]));
            check("tt_co", 65'(co1), 65'(co_tab[i]));
        end
        @(negedge clk);
        rst_n = 1;
        a8 = 8'hFF; b8 = 8'h01; ci = 0;
        #1 check("wrap", {co8, s8}, 65'h100);
        a8 = 8'h7F; b8 = 8'h00; ci = 1;
        #1 check("carry_in", {co8, s8}, 65'h080);
        check("fresh_q", {coq8, sq8}, 65'h0);
        a8 = 8'h12; b8 = 8'h34; ci = 1; en = 1;
        @(posedge clk) #1 check("cap", {coq8, sq8}, 65'h047);
        @(negedge clk) en = 0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom()); b8 = 8'($urandom()); ci = 1'($urandom());
            #1 check_comb();
            @(posedge clk) #1 check("hold", {coq8, sq8}, 65'h047);
            @(negedge clk);
        end
        a8 = 8'h12; b8 = 8'h34; ci = 1;
        #2 rst_n = 0;
        #1;
        check("async_rst_q", {coq8, sq8}, 65'h0);
        check("async_rst_s", {co8, s8}, 65'h047);
        rst_n = 1;
        q1 = 0; q8 = 0; q32 = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            a1 = 1'($urandom()); b1 = 1'($urandom());
            a8 = 8'($urandom()); b8 = 8'($urandom());
            a32 = $urandom(); b32 = $urandom();
            ci = 1'($urandom());
            en = ($urandom_range(0, 3) != 0);
            #1 check_comb();
            @(posedge clk) #1;
            if (en) begin
                q1 = e1; q8 = e8; q32 = e32;
            end
            check_reg();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fa_using_2ha.md
FA_USING_2HA -- requirements
Module: fa_using_2ha

Interface
REQ-001 SHALL have parameter WIDTH, default 1, operand width in bits (legal range 1..64).
REQ-002 SHALL have port clk, input, 1, single clock; rising edge is active.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port a, input, WIDTH, addend A.
REQ-005 SHALL have port b, input, WIDTH, addend B.
REQ-006 SHALL have port ci, input, 1, carry-in into bit 0.
REQ-007 SHALL have port en, input, 1, capture enable for the registered outputs.
REQ-008 SHALL have port s, output, WIDTH, combinational sum.
REQ-009 SHALL have port co, output, 1, combinational carry-out from the MSB.
REQ-010 SHALL have port s_q, output, WIDTH, registered sum.
REQ-011 SHALL have port co_q, output, 1, registered carry-out.

Function
REQ-012 {co,s} SHALL equal a + b + ci, computed in WIDTH+1 bits; there is no saturation, and wrap-around is reported only through co.
REQ-013 Each bit i SHALL be built from two half adders.
- HA1: p_i = a_i ^ b_i, g1_i = a_i & b_i.
- HA2: s_i = p_i ^ c_i, g2_i = p_i & c_i.
- Carry out of bit i: c_(i+1) = g1_i | g2_i.
REQ-014 c_0 SHALL be ci, and co SHALL be c_WIDTH; the carry SHALL ripple from LSB to MSB with no lookahead.
REQ-015 s and co SHALL be purely combinational from a, b and ci, with zero-cycle latency, and SHALL be independent of clk, rst_n and en.
REQ-016 For WIDTH=1, the truth table SHALL be s = a^b^ci and co = majority(a,b,ci) for all 8 input combinations.
REQ-017 On a rising clk edge with en=1, s_q SHALL load s and co_q SHALL load co; s_q and co_q therefore lag the inputs by exactly 1 cycle.
REQ-018 On a rising clk edge with en=0, s_q and co_q SHALL hold their values.
REQ-019 Inputs that change between clock edges SHALL affect s and co immediately and s_q and co_q only at the next enabled edge.
REQ-020 X/Z on any input bit SHALL NOT propagate into bits below that position, through either sum or carry.

Reset
REQ-021 rst_n=0 SHALL asynchronously force s_q=0 and co_q=0, independent of clk and en.
REQ-022 Assertion of rst_n mid-operation SHALL clear s_q and co_q immediately and SHALL NOT affect s or co.
REQ-023 After rst_n deasserts, the first capture SHALL occur on the first rising clk edge with en=1.

Structure
REQ-024 A sub-module half_adder with ports x, y, sum and carry SHALL be instantiated 2*WIDTH times; there SHALL be no other sub-modules.
REQ-025 A shared package fa_pkg SHALL hold the WIDTH default constant and a sum-plus-carry result typedef of WIDTH+1 bits.
REQ-026 There SHALL be exactly one always block, sequential only, for s_q and co_q; the combinational path SHALL consist of half_adder instances plus OR gates.

Verification
REQ-027 WIDTH=1, stepping ci every 1 ns, b every 2 ns and a every 4 ns over 8 ns -> s = 0,1,1,0,1,0,0,1 and co = 0,0,0,1,0,1,1,1.
REQ-028 WIDTH=8: a=0xFF, b=0x01, ci=0 -> s=0x00, co=1; a=0x7F, b=0x00, ci=1 -> s=0x80, co=0.
REQ-029 WIDTH=8, en=1, a=0x12, b=0x34, ci=1 applied before edge N -> s_q=0x47 and co_q=0 after edge N, and 0 before edge N if freshly reset.
REQ-030 en=0 while inputs change over 3 edges -> s_q and co_q hold the prior values; s tracks the inputs combinationally.
REQ-031 rst_n pulsed low between edges while s_q=0x47 -> s_q=0 and co_q=0 immediately, with no clk edge needed, while s stays 0x47.
REQ-032 Random 10k vectors for WIDTH in {1,8,32} -> {co,s} matches a+b+ci exactly, and {co_q,s_q} matches the value from the previous enabled cycle.
